cpu4_seq_ctrl: RTL and testbench

CPU4_SEQ_CTRL -- requirements
Module: cpu4_seq_ctrl

---
 rtl/cpu4_pkg.sv | 32 +++
 rtl/cpu4_retire_ctr.sv | 25 ++
 rtl/cpu4_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_cpu4_seq_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu4_pkg.sv
// Shared definitions for the 4-bit CPU sequencer: opcode constants, the
// sequencer state enum and opcode classification helpers.
package cpu4_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MOV  = 3'b010;
  localparam logic [2:0] OP_IMM  = 3'b011;
  localparam logic [2:0] OP_NOP0 = 3'b100;
  localparam logic [2:0] OP_NOP1 = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b110;
  localparam logic [2:0] OP_NOP2 = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXEC      = 3'd3,
    ST_STEP_WAIT = 3'd4,
    ST_HALTED    = 3'd5
  } state_t;

  // Opcodes 000..011 write the register file; the upper half never does.
  function automatic logic is_write_op(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic is_halt_op(input logic [2:0] op);
    return (op == OP_HALT);
  endfunction

endpackage

// File: rtl/cpu4_retire_ctr.sv
// Saturating retired-instruction counter; holds at all-ones instead of wrapping.
module cpu4_retire_ctr #(
  parameter int RETIRE_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inc,
  output logic [RETIRE_W-1:0] count
);

  localparam logic [RETIRE_W-1:0] CNT_MAX = {RETIRE_W{1'b1}};
  localparam logic [RETIRE_W-1:0] CNT_ONE = RETIRE_W'(1);

  // Count retirements, clamping at the maximum value.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= {RETIRE_W{1'b0}};
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/cpu4_seq_ctrl.sv
// Fetch/decode/execute sequencer for the 4-bit CPU. Define CPU4_SINGLE_STEP_EN
// to compile in the single-step pause (STEP_WAIT) with step_mode/step_req/step_ack.
module cpu4_seq_ctrl
  import cpu4_pkg::*;
#(
  parameter int RETIRE_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [2:0]          opcode,
  input  logic                step_mode,
  input  logic                step_req,
  output logic                ir_load,
  output logic                pc_en,
  output logic                rf_wr_en,
  output logic                alu_b_sel,
  output logic                halt,
  output logic                busy,
  output logic                step_ack,
  output logic [RETIRE_W-1:0] retired
);

  state_t     state;
  state_t     next_state;
  logic [2:0] op_reg;
  logic       retire_inc;
  logic       step_pause;

`ifdef CPU4_SINGLE_STEP_EN
  assign step_pause = step_mode;
`else
  logic unused_step;
  assign step_pause  = 1'b0;
  assign unused_step = step_mode | step_req;
`endif

  // State register and opcode latch captured during DECODE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      op_reg <= 3'b000;
    end else begin
      state <= next_state;
      if (state == ST_DECODE) begin
        op_reg <= opcode;
      end else begin
        op_reg <= op_reg;
      end
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    next_state = state;
    ir_load    = 1'b0;
    pc_en      = 1'b0;
    rf_wr_en   = 1'b0;
    alu_b_sel  = 1'b0;
    halt       = 1'b0;
    step_ack   = 1'b0;
    retire_inc = 1'b0;
    busy       = (state != ST_IDLE) && (state != ST_HALTED);
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = ST_FETCH;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_FETCH: begin
        ir_load    = 1'b1;
        next_state = ST_DECODE;
      end
      ST_DECODE: begin
        alu_b_sel  = (opcode == OP_IMM);
        next_state = ST_EXEC;
      end
      ST_EXEC: begin
        alu_b_sel = (op_reg == OP_IMM);
        // halt rises in the halting EXEC cycle so it lines up with pc_en staying low.
        if (is_halt_op(op_reg)) begin
          halt       = 1'b1;
          next_state = ST_HALTED;
        end else begin
          pc_en      = 1'b1;
          rf_wr_en   = is_write_op(op_reg);
          retire_inc = 1'b1;
          if (step_pause) begin
            next_state = ST_STEP_WAIT;
          end else begin
            next_state = ST_FETCH;
          end
        end
      end
      ST_STEP_WAIT: begin
`ifdef CPU4_SINGLE_STEP_EN
        if (step_req) begin
          step_ack   = 1'b1;
          next_state = ST_FETCH;
        end else if (!step_mode) begin
          next_state = ST_FETCH;
        end else begin
          next_state = ST_STEP_WAIT;
        end
`else
        next_state = ST_IDLE;
`endif
      end
      ST_HALTED: begin
        halt       = 1'b1;
        next_state = ST_HALTED;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  cpu4_retire_ctr #(
    .RETIRE_W(RETIRE_W)
  ) u_retire_ctr (
    .clk  (clk),
    .reset(reset),
    .inc  (retire_inc),
    .count(retired)
  );

endmodule

// File: tb/tb_cpu4_seq_ctrl.sv
// Scoreboard bench for cpu4_seq_ctrl: a program-level reference model queues
// per-cycle expectations; a negedge monitor compares two DUTs (RETIRE_W 8 and 2).
module tb_cpu4_seq_ctrl;

  logic       clk = 1'b1;
  logic       reset, start, step_mode, step_req;
  logic [2:0] opcode;

  logic [6:0] o8, o2;
  logic [7:0] ret8;
  logic [1:0] ret2;

  always #5 clk = ~clk;

  cpu4_seq_ctrl #(.RETIRE_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .step_mode(step_mode), .step_req(step_req),
    .ir_load(o8[6]), .pc_en(o8[5]), .rf_wr_en(o8[4]), .alu_b_sel(o8[3]),
    .halt(o8[2]), .busy(o8[1]), .step_ack(o8[0]), .retired(ret8)
  );

  cpu4_seq_ctrl #(.RETIRE_W(2)) dut_w2 (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .step_mode(step_mode), .step_req(step_req),
    .ir_load(o2[6]), .pc_en(o2[5]), .rf_wr_en(o2[4]), .alu_b_sel(o2[3]),
    .halt(o2[2]), .busy(o2[1]), .step_ack(o2[0]), .retired(ret2)
  );

`ifdef CPU4_SINGLE_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  typedef struct {
    bit         chk;
    logic [6:0] o;
    int         r8;
    int         r2;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         retired_cnt = 0;
  bit         chk_on = 1'b0;
  logic [6:0] rest_o = 7'b0000000;

  // Output vector order: ir_load pc_en rf_wr_en alu_b_sel halt busy step_ack.
  function automatic logic [6:0] ov(input bit ir, input bit pc, input bit wr,
                                    input bit ab, input bit h, input bit b, input bit ack);
    return {ir, pc, wr, ab, h, b, ack};
  endfunction

  function automatic logic [2:0] rnd_op();
    return 3'($urandom_range(0, 7));
  endfunction

  function automatic bit rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Monitor: every cycle the DUTs present outputs; pop and compare.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      if (mon_e.chk) begin
        n_cmp++;
        if (o8 !== mon_e.o || ret8 !== 8'(mon_e.r8)) begin
          n_bad++;
          $display("FAIL out_w8 t=%0t got ir/pc/wr/ab/h/busy/ack=%b retired=%0d want %b retired=%0d",
                   $time, o8, ret8, mon_e.o, mon_e.r8);
        end
        n_cmp++;
        if (o2 !== mon_e.o || ret2 !== 2'(mon_e.r2)) begin
          n_bad++;
          $display("FAIL out_w2 t=%0t got ir/pc/wr/ab/h/busy/ack=%b retired=%0d want %b retired=%0d",
                   $time, o2, ret2, mon_e.o, mon_e.r2);
        end
      end
    end
  end

  task automatic tick(input bit rst, input bit st, input logic [2:0] op,
                      input bit sm, input bit sr, input logic [6:0] exp_o);
    exp_t e;
    reset = rst; start = st; opcode = op; step_mode = sm; step_req = sr;
    e.chk = chk_on;
    e.o   = exp_o;
    e.r8  = (retired_cnt > 255) ? 255 : retired_cnt;
    e.r2  = (retired_cnt > 3) ? 3 : retired_cnt;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick(1'b1, rnd_bit(), rnd_op(), rnd_bit(), rnd_bit(), rest_o);
    retired_cnt = 0;
    rest_o      = 7'b0000000;
    chk_on      = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, rnd_op(), rnd_bit(), rnd_bit(), 7'b0000000);
  endtask

  task automatic start_prog();
    tick(1'b0, 1'b1, rnd_op(), rnd_bit(), 1'b0, 7'b0000000);
  endtask

  task automatic halted(input int n);
    for (int i = 0; i < n; i++)
      tick(1'b0, (i == 0) ? 1'b1 : rnd_bit(), rnd_op(), rnd_bit(), rnd_bit(), ov(0, 0, 0, 0, 1, 0, 0));
  endtask

  // One instruction; rst_at 1/2/3 resets in FETCH/DECODE/EXEC, 4 right after EXEC.
  task automatic run_instr(input logic [2:0] op, input bit sm, input int rst_at);
    bit is_halt, pause;
    is_halt = (op == 3'b110);
    tick(rst_at == 1, rnd_bit(), rnd_op(), rnd_bit(), rnd_bit(), ov(1, 0, 0, 0, 0, 1, 0));
    if (rst_at == 1) begin retired_cnt = 0; rest_o = 7'b0; return; end
    tick(rst_at == 2, rnd_bit(), op, rnd_bit(), rnd_bit(), ov(0, 0, 0, op == 3'b011, 0, 1, 0));
    if (rst_at == 2) begin retired_cnt = 0; rest_o = 7'b0; return; end
    tick(rst_at == 3, 1'b1, rnd_op(), sm, 1'b0,
         ov(0, !is_halt, op < 3'd4, op == 3'b011, is_halt, 1, 0));
    if (rst_at == 3) begin retired_cnt = 0; rest_o = 7'b0; return; end
    if (is_halt) begin rest_o = ov(0, 0, 0, 0, 1, 0, 0); return; end
    retired_cnt++;
    pause = STEP_EN && sm;
    if (rst_at == 4) begin
      tick(1'b1, rnd_bit(), rnd_op(), 1'b1, 1'b0, pause ? ov(0, 0, 0, 0, 0, 1, 0) : ov(1, 0, 0, 0, 0, 1, 0));
      retired_cnt = 0; rest_o = 7'b0;
      return;
    end
    if (pause) begin
      repeat ($urandom_range(0, 3)) tick(1'b0, rnd_bit(), rnd_op(), 1'b1, 1'b0, ov(0, 0, 0, 0, 0, 1, 0));
      if (rnd_bit()) tick(1'b0, rnd_bit(), rnd_op(), 1'b1, 1'b1, ov(0, 0, 0, 0, 0, 1, 1));
      else           tick(1'b0, rnd_bit(), rnd_op(), 1'b0, 1'b0, ov(0, 0, 0, 0, 0, 1, 0));
    end
    rest_o = ov(1, 0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    logic [2:0] op;
    int         len, rpos, rkind;
    bit         sm;
    reset = 1'b1; start = 1'b0; opcode = 3'b000; step_mode = 1'b0; step_req = 1'b0;

    // program 000, 011, 110
    do_reset();
    idle(2);
    start_prog();
    run_instr(3'b000, 1'b0, 0);
    run_instr(3'b011, 1'b0, 0);
    run_instr(3'b110, 1'b0, 0);
    halted(4);

    // NOP 101 then halt
    do_reset();
    start_prog();
    run_instr(3'b101, 1'b0, 0);
    run_instr(3'b110, 1'b0, 0);
    halted(2);

    // five NOPs: narrow counter saturates
    do_reset();
    start_prog();
    run_instr(3'b100, 1'b0, 0);
    run_instr(3'b101, 1'b0, 0);
    run_instr(3'b111, 1'b0, 0);
    run_instr(3'b100, 1'b0, 0);
    run_instr(3'b111, 1'b0, 0);
    run_instr(3'b110, 1'b0, 0);
    halted(2);

    // reset during DECODE, then restart
    do_reset();
    start_prog();
    run_instr(3'b001, 1'b0, 0);
    run_instr(3'b010, 1'b0, 2);
    idle(2);
    start_prog();
    run_instr(3'b011, 1'b0, 0);
    run_instr(3'b110, 1'b0, 0);
    halted(2);

    // step mode: pauses only when single-step is compiled in
    do_reset();
    start_prog();
    run_instr(3'b001, 1'b1, 0);
    run_instr(3'b100, 1'b1, 0);
    run_instr(3'b000, 1'b1, 4);
    idle(1);
    start_prog();
    run_instr(3'b011, 1'b1, 0);
    run_instr(3'b110, 1'b0, 0);
    halted(3);

    // randomized programs
    for (int it = 0; it < 60; it++) begin
      do_reset();
      idle($urandom_range(0, 2));
      start_prog();
      len  = $urandom_range(1, 7);
      rpos = $urandom_range(0, 3 * len);
      for (int k = 0; k < len; k++) begin
        op = rnd_op();
        if (op == 3'b110 && k != len - 1) op = 3'b111;
        sm    = rnd_bit();
        rkind = (k == rpos) ? $urandom_range(1, 4) : 0;
        run_instr(op, sm, rkind);
        if (rkind != 0) break;
        if (op == 3'b110) begin
          halted($urandom_range(1, 3));
          break;
        end
      end
    end

    do_reset();
    idle(2);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
